task_issuer: RTL
================

TASK_ISSUER -- requirements
Module: task_issuer

Interface
REQ-001 SHALL have parameter PTW, default 16: priority field width.
REQ-002 SHALL have parameter MTW, default 0: metadata field width; data width DW = MTW+PTW.
REQ-003 SHALL have parameter TREE_NUM, default 4: number of trees; TIDW = clog2(TREE_NUM).
REQ-004 SHALL have parameter TREE_CAP, default 15: maximum elements per tree.
REQ-005 SHALL have parameter POP_LAT, default 2: cycles from generator pop strobe to valid pop tree id/data.
REQ-006 SHALL have parameter CNTW, default clog2(TREE_NUM*TREE_CAP+1): total-count width.
REQ-007 One clock; reset is asynchronous and active-high.
REQ-008 i_clk  in  1  clock, all logic on rising edge.
REQ-009 i_arst  in  1  asynchronous active-high reset.
REQ-010 i_cmd_valid  in  1  upstream command valid.
REQ-011 o_cmd_ready  out  1  command accepted when valid and ready both high.
REQ-012 i_cmd_op  in  1  1 = push, 0 = pop.
REQ-013 i_cmd_tree_id  in  TIDW  target tree for push; ignored for pop.
REQ-014 i_cmd_data  in  DW  push data; ignored for pop.
REQ-015 o_push, o_push_tree_id, o_push_data  out  1/TIDW/DW  push strobe, tree id and data to the task generator.
REQ-016 o_pop  out  1  pop strobe to the task generator.
REQ-017 i_pop_tree_id, i_pop_data  in  TIDW/DW  generator pop result.
REQ-018 i_task_fifo_full  in  1  generator backpressure.
REQ-019 o_rsp_valid, o_rsp_tree_id, o_rsp_data  out  1/TIDW/DW  registered pop response.
REQ-020 o_err_push_full, o_err_pop_empty  out  1  one-cycle error pulses.
REQ-021 o_total_cnt  out  CNTW  elements held plus pops not yet issued-against; o_idle  out  1  nothing stored and no pop in flight.

Function
REQ-022 o_cmd_ready SHALL equal !i_task_fifo_full; at most one command accepted per cycle.
REQ-023 Accepted push with occ[tree_id] < TREE_CAP SHALL drive o_push=1 with that tree id/data the next cycle and increment occ[tree_id] and total.
REQ-024 Accepted push with occ[tree_id] == TREE_CAP SHALL be dropped and pulse o_err_push_full the next cycle.
REQ-025 Accepted pop with total > 0 SHALL drive o_pop=1 the next cycle, decrement total, and enter a POP_LAT-deep in-flight delay line.
REQ-026 Accepted pop with total == 0 SHALL be dropped and pulse o_err_pop_empty the next cycle.
REQ-027 When the delay-line tap fires (cycle T+POP_LAT, o_pop at T), SHALL sample i_pop_tree_id/i_pop_data, decrement occ[i_pop_tree_id], and present o_rsp_* with o_rsp_valid=1 at T+POP_LAT+1.
REQ-028 Push to tree k and response from tree k in the same cycle SHALL leave occ[k] unchanged.
REQ-029 Back-to-back pops SHALL each produce exactly one response, in issue order, no bubbles added.
REQ-030 o_push and o_pop SHALL never be high in the same cycle; all strobes are single-cycle.
REQ-031 o_idle SHALL be 1 iff total == 0 and the delay line is empty.
REQ-032 Response tree id >= TREE_NUM or occ underflow SHALL saturate at 0 (no wrap).

Reset
REQ-033 i_arst SHALL asynchronously clear occ[], total, delay line and every output to 0 except o_idle=1; o_cmd_ready follows i_task_fifo_full.
REQ-034 Reset mid-operation SHALL discard in-flight pops; no o_rsp_valid after reset release for pops issued before it.

Structure
REQ-035 DW, TIDW, CNTW and the command op encoding SHALL live in a shared package task_pkg.
REQ-036 The pop delay line SHALL be one sub-module, pop_lat_pipe (POP_LAT-stage valid shift register).

Verification
REQ-037 Push 4096*i+j, i=1..3, j=1..4, one per cycle -> 12 o_push pulses one cycle after each accept, occ=4 per tree 1..3, o_total_cnt=12.
REQ-038 Then 12 pops back-to-back -> 12 o_pop, 12 o_rsp_valid each POP_LAT+1 after its o_pop, all occ 0, o_idle=1.
REQ-039 16 pushes to tree 2 -> 15 o_push, 16th gives o_err_push_full, occ[2]=15.
REQ-040 Pop with total 0 -> no o_pop, o_err_pop_empty pulse, counters unchanged.
REQ-041 Hold i_task_fifo_full=1 for 5 cycles with i_cmd_valid=1 -> o_cmd_ready=0, no strobes; first accept on release.
REQ-042 Assert i_arst one cycle after 2 pops issued -> no o_rsp_valid afterward, o_total_cnt=0, o_idle=1.

Source files
------------

// File: rtl/task_pkg.sv
// Shared definitions for the task issuer: default configuration,
// derived widths for that configuration, and the command op encoding.
package task_pkg;

    // Width of an index into n items; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned PTW_DEF      = 16;
    localparam int unsigned MTW_DEF      = 0;
    localparam int unsigned TREE_NUM_DEF = 4;
    localparam int unsigned TREE_CAP_DEF = 15;
    localparam int unsigned POP_LAT_DEF  = 2;

    localparam int unsigned DW   = MTW_DEF + PTW_DEF;
    localparam int unsigned TIDW = id_width(TREE_NUM_DEF);
    localparam int unsigned CNTW = $clog2(TREE_NUM_DEF * TREE_CAP_DEF + 1);

    typedef enum logic {
        OP_POP  = 1'b0,
        OP_PUSH = 1'b1
    } cmd_op_e;

endpackage

// File: rtl/pop_lat_pipe.sv
// Valid-only delay line tracking pops in flight inside the task generator.
// A bit entering at i_in appears on o_tap DEPTH cycles later.
module pop_lat_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_in,
    output logic o_tap,
    output logic o_busy
);

    logic [DEPTH-1:0] stage;

    // Shift the in-flight markers one stage per cycle; reset drops them all.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            stage <= '0;
        end else begin
            stage <= (stage << 1) | DEPTH'(i_in);
        end
    end

    assign o_tap  = stage[DEPTH-1];
    assign o_busy = |stage;

endmodule

// File: rtl/task_issuer.sv
// Task issuer: accepts push/pop commands, tracks per-tree occupancy and
// a global element count, and forwards strobes to the task generator.
// Handshake: a command transfers on a rising edge where i_cmd_valid and
// o_cmd_ready are both high; o_cmd_ready depends only on the generator's
// fifo-full backpressure, never on i_cmd_valid.
module task_issuer #(
    parameter int unsigned PTW      = task_pkg::PTW_DEF,
    parameter int unsigned MTW      = task_pkg::MTW_DEF,
    parameter int unsigned TREE_NUM = task_pkg::TREE_NUM_DEF,
    parameter int unsigned TREE_CAP = task_pkg::TREE_CAP_DEF,
    parameter int unsigned POP_LAT  = task_pkg::POP_LAT_DEF,
    parameter int unsigned CNTW     = $clog2(TREE_NUM * TREE_CAP + 1),
    localparam int unsigned DW      = MTW + PTW,
    localparam int unsigned TIDW    = task_pkg::id_width(TREE_NUM)
) (
    input  logic            i_clk,
    input  logic            i_arst,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic            i_cmd_op,
    input  logic [TIDW-1:0] i_cmd_tree_id,
    input  logic [DW-1:0]   i_cmd_data,
    output logic            o_push,
    output logic [TIDW-1:0] o_push_tree_id,
    output logic [DW-1:0]   o_push_data,
    output logic            o_pop,
    input  logic [TIDW-1:0] i_pop_tree_id,
    input  logic [DW-1:0]   i_pop_data,
    input  logic            i_task_fifo_full,
    output logic            o_rsp_valid,
    output logic [TIDW-1:0] o_rsp_tree_id,
    output logic [DW-1:0]   o_rsp_data,
    output logic            o_err_push_full,
    output logic            o_err_pop_empty,
    output logic [CNTW-1:0] o_total_cnt,
    output logic            o_idle
);

    import task_pkg::OP_PUSH;

    localparam int unsigned OCCW = $clog2(TREE_CAP + 1);

    logic [OCCW-1:0]     occ [TREE_NUM];
    logic [CNTW-1:0]     total;
    logic                cmd_acc;
    logic                is_push;
    logic                is_pop;
    logic                push_ok;
    logic                pop_ok;
    logic [OCCW-1:0]     occ_sel;
    logic                tid_in_range;
    logic [TREE_NUM-1:0] occ_inc;
    logic [TREE_NUM-1:0] occ_dec;
    logic                pipe_tap;
    logic                pipe_busy;

    assign o_cmd_ready = ~i_task_fifo_full;
    assign cmd_acc     = i_cmd_valid & o_cmd_ready;
    assign is_push     = cmd_acc & (i_cmd_op == OP_PUSH);
    assign is_pop      = cmd_acc & (i_cmd_op != OP_PUSH);

    // Occupancy of the addressed tree; an id with no tree behind it counts as full.
    always_comb begin
        occ_sel      = '0;
        tid_in_range = 1'b0;
        for (int k = 0; k < TREE_NUM; k++) begin
            if (i_cmd_tree_id == TIDW'(k)) begin
                occ_sel      = occ[k];
                tid_in_range = 1'b1;
            end
        end
    end

    assign push_ok = is_push & tid_in_range & (occ_sel < OCCW'(TREE_CAP));
    assign pop_ok  = is_pop & (total != '0);

    // Per-tree up/down requests; a response never takes a tree below zero.
    always_comb begin
        occ_inc = '0;
        occ_dec = '0;
        for (int k = 0; k < TREE_NUM; k++) begin
            occ_inc[k] = push_ok & (i_cmd_tree_id == TIDW'(k));
            occ_dec[k] = pipe_tap & (i_pop_tree_id == TIDW'(k)) & (occ[k] != '0);
        end
    end

    // Per-tree occupancy: simultaneous push and response on one tree cancel out.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int k = 0; k < TREE_NUM; k++) begin
                occ[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TREE_NUM; k++) begin
                occ[k] <= occ[k] + OCCW'(occ_inc[k]) - OCCW'(occ_dec[k]);
            end
        end
    end

    // Global count: pops are charged at issue time, so back-to-back pops see it drop.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            total <= '0;
        end else if (push_ok) begin
            total <= total + CNTW'(1);
        end else if (pop_ok) begin
            total <= total - CNTW'(1);
        end
    end

    // Generator strobes and error pulses, one cycle after the accepting edge.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_push          <= 1'b0;
            o_push_tree_id  <= '0;
            o_push_data     <= '0;
            o_pop           <= 1'b0;
            o_err_push_full <= 1'b0;
            o_err_pop_empty <= 1'b0;
        end else begin
            o_push          <= push_ok;
            o_pop           <= pop_ok;
            o_err_push_full <= is_push & ~push_ok;
            o_err_pop_empty <= is_pop & ~pop_ok;
            if (push_ok) begin
                o_push_tree_id <= i_cmd_tree_id;
                o_push_data    <= i_cmd_data;
            end
        end
    end

    pop_lat_pipe #(
        .DEPTH (POP_LAT)
    ) u_pop_lat_pipe (
        .i_clk  (i_clk),
        .i_arst (i_arst),
        .i_in   (o_pop),
        .o_tap  (pipe_tap),
        .o_busy (pipe_busy)
    );

    // Capture the generator's pop result on the cycle its latency expires.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_rsp_valid   <= 1'b0;
            o_rsp_tree_id <= '0;
            o_rsp_data    <= '0;
        end else begin
            o_rsp_valid <= pipe_tap;
            if (pipe_tap) begin
                o_rsp_tree_id <= i_pop_tree_id;
                o_rsp_data    <= i_pop_data;
            end
        end
    end

    assign o_total_cnt = total;
    assign o_idle      = (total == '0) & ~o_pop & ~pipe_busy;

endmodule
